// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time through IDLE/ACCESS/MERGE/RESP, byte/halfword stores by read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned or illegal requests instead of silently aligning them.
module load_store_unit #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [31:0] mem_read_data,
   output logic [1:0]  state_dbg,
   output logic        addr_in_range_dbg
);

   // req_valid/req_ready: a request transfers on a rising edge where both are high.
   // req_ready is high only in IDLE; request inputs are ignored in every other state.

`ifdef LSU_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

   typedef struct packed {
      logic [1:0] size;
      logic       uns;
      logic       mis;
      logic [1:0] off;
   } dec_t;

   state_t      state;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   dec_t        dec_q;

   // Illegal codes collapse to a word access; without the trap they also get aligned down.
   function automatic dec_t decode(input logic we, input logic [2:0] f3, input logic [1:0] a);
      dec_t d;
      logic illegal;
      illegal = (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1]));
      d.size  = illegal ? SZ_W : f3[1:0];
      d.uns   = f3[2] & ~illegal;
      d.mis   = TRAP_EN & (illegal || (d.size == SZ_H && a[0]) || (d.size == SZ_W && a != 2'b00));
      case (d.size)
         SZ_B:    d.off = a;
         SZ_H:    d.off = {a[1], 1'b0};
         default: d.off = 2'b00;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         SZ_B:    extract = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         SZ_H:    extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: extract = sh;
      endcase
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [15:0] data,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      r = word;
      if (size == SZ_B) r[{off, 3'b000} +: 8] = data[7:0];
      else              r[{off[1], 4'b0000} +: 16] = data;
      return r;
   endfunction

   always_comb dec_q = decode(we_q, funct3_q, addr_q[1:0]);

   assign req_ready         = (state == IDLE);
   assign state_dbg         = state;
   assign addr_in_range_dbg = ({2'b00, addr_q[31:2]} < 32'(MEM_WORDS));

   // Memory-side signals decode only registered state, so reset drops them immediately.
   assign mem_address      = (state == ACCESS || state == MERGE) ? {addr_q[31:2], 2'b00} : 32'h0;
   assign mem_write_enable = (state == ACCESS && we_q && dec_q.size == SZ_W && !dec_q.mis)
                             || (state == MERGE);
   assign mem_write_data   = (state == MERGE) ? merge_q :
                             (state == ACCESS && we_q) ? wdata_q : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         funct3_q   <= 3'b000;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         merge_q    <= 32'h0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (dec_q.mis) begin
                  resp_rdata <= 32'h0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (!we_q) begin
                  resp_rdata <= extract(mem_read_data, dec_q.size, dec_q.uns, dec_q.off);
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (dec_q.size == SZ_W) begin
                  resp_rdata <= 32'h0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  merge_q <= merge_word(mem_read_data, wdata_q[15:0], dec_q.size, dec_q.off);
                  state   <= MERGE;
               end
            end
            MERGE: begin
               resp_rdata <= 32'h0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                mis_q <= 1'b0;
      else if (state == ACCESS)  mis_q <= dec_q.mis;
   end

   assign resp_misaligned = mis_q;
`else
   assign resp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases, reset abort, random traffic and back-to-back streaming
// against a byte-level reference memory model.
module tb_load_store_unit;

   localparam int MEM_WORDS = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;
   logic [1:0]  state_dbg;
   logic        addr_in_range_dbg;

   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   logic [32:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
      .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
      .mem_read_data(mem_read_data), .state_dbg(state_dbg), .addr_in_range_dbg(addr_in_range_dbg)
   );

   // ---------------- clock / attached memory ----------------
   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address[9:2]];

   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_address[9:2]] <= mem_write_data;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (byte-level memory semantics) ----------------
   function automatic void model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wdata, output logic [31:0] rdata,
                                     output logic mis, output logic writes, output int lat,
                                     output logic [31:0] waddr);
      int code, n, idx, pos;
      logic illegal;
      logic [31:0] a, mask, v;
      code    = int'(f3);
      illegal = !(code inside {0, 1, 2, 4, 5}) || (we && code >= 4);
      n       = illegal ? 4 : (1 << (code % 4));
`ifdef LSU_MISALIGN_TRAP_EN
      mis = illegal || ((addr % 32'(n)) != 32'd0);
`else
      mis = 1'b0;
`endif
      a      = addr - (addr % 32'(n));
      idx    = int'((a / 32'd4) % 32'(MEM_WORDS));
      pos    = int'(a % 32'd4);
      rdata  = 32'h0;
      writes = 1'b0;
      lat    = 2;
      waddr  = a - (a % 32'd4);
      if (mis) return;
      if (!we) begin
         mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
         v    = (ref_mem[idx] >> (8 * pos)) & mask;
         if (code < 4 && n < 4 && v[8 * n - 1]) v = v | ~mask;
         rdata = v;
      end else begin
         for (int b = 0; b < n; b++) ref_mem[idx][8 * (pos + b) +: 8] = wdata[8 * b +: 8];
         writes = 1'b1;
         lat    = (n == 4) ? 2 : 3;
      end
   endfunction

   // ---------------- driver ----------------
   // Issues one request, then observes each following cycle (k = 1 is the cycle after the accept edge).
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic mis, output int lat, output int nwr,
                         output int wr_k, output logic [31:0] wr_data, output logic [31:0] wr_addr);
      int wait_n;
      rdata = 32'hx; mis = 1'bx; lat = -1; nwr = 0; wr_k = -1; wr_data = 32'hx; wr_addr = 32'hx;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      wait_n = 0;
      while (!req_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom_range(0, 7));
      req_addr = $urandom; req_wdata = $urandom;
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clk);
         if (mem_write_enable) begin
            nwr++; wr_k = k; wr_data = mem_write_data; wr_addr = mem_address;
         end
         if (resp_valid) begin
            lat = k; rdata = resp_rdata; mis = resp_misaligned;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = $urandom; req_wdata = $urandom;
      repeat (3) @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
      n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
      n_checks++; if (resp_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b expected 0", resp_misaligned); end
      n_checks++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_write_enable); end
      n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
      req_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
   endtask

   task automatic test_loads;
      logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [31:0] adrs [5] = '{32'h12F, 32'h12C, 32'h12E, 32'h12C, 32'h12C};
      logic [31:0] exps [5] = '{32'hFFFF_FFDE, 32'h0000_00EF, 32'hFFFF_DEAD, 32'h0000_BEEF, 32'hDEAD_BEEF};
      logic [31:0] rd, wa, wd;
      logic ms;
      int lat, nwr, wk;
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, f3s[i], adrs[i], $urandom, rd, ms, lat, nwr, wk, wd, wa);
         n_checks++; if (rd !== exps[i]) begin n_fail++; $display("FAIL load_rdata[%0d]: got %h expected %h", i, rd, exps[i]); end
         n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL load_latency[%0d]: got %0d expected 2", i, lat); end
         n_checks++; if (nwr !== 0) begin n_fail++; $display("FAIL load_writes[%0d]: got %0d expected 0", i, nwr); end
      end
   endtask

   task automatic test_misaligned;
      logic [31:0] rd, wa, wd, e_rd, e_wa;
      logic ms, e_ms, e_wr;
      int lat, nwr, wk, e_lat;
      do_req(1'b0, 3'b010, 32'h12E, 32'h0, rd, ms, lat, nwr, wk, wd, wa);
`ifdef LSU_MISALIGN_TRAP_EN
      n_checks++; if (ms !== 1'b1) begin n_fail++; $display("FAIL mis_lw_flag: got %b expected 1", ms); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_lw_rdata: got %h expected 0", rd); end
`else
      n_checks++; if (ms !== 1'b0) begin n_fail++; $display("FAIL mis_lw_flag: got %b expected 0", ms); end
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mis_lw_rdata: got %h expected deadbeef", rd); end
`endif
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL mis_lw_latency: got %0d expected 2", lat); end
      n_checks++; if (nwr !== 0) begin n_fail++; $display("FAIL mis_lw_writes: got %0d expected 0", nwr); end
      model_req(1'b0, 3'b011, 32'h12D, 32'h0, e_rd, e_ms, e_wr, e_lat, e_wa);
      do_req(1'b0, 3'b011, 32'h12D, 32'h0, rd, ms, lat, nwr, wk, wd, wa);
      n_checks++; if ({ms, rd} !== {e_ms, e_rd}) begin n_fail++; $display("FAIL illegal_code: got %b/%h expected %b/%h", ms, rd, e_ms, e_rd); end
   endtask

   task automatic test_stores;
      logic [31:0] rd, wa, wd, e_rd, e_wa;
      logic ms, e_ms, e_wr;
      int lat, nwr, wk, e_lat;
      model_req(1'b1, 3'b000, 32'h12D, 32'h0000_00AB, e_rd, e_ms, e_wr, e_lat, e_wa);
      do_req(1'b1, 3'b000, 32'h12D, 32'h0000_00AB, rd, ms, lat, nwr, wk, wd, wa);
      n_checks++; if (nwr !== 1) begin n_fail++; $display("FAIL sb_writes: got %0d expected 1", nwr); end
      n_checks++; if (wk !== 2) begin n_fail++; $display("FAIL sb_write_cycle: got %0d expected 2", wk); end
      n_checks++; if (wd !== 32'hDEAD_ABEF) begin n_fail++; $display("FAIL sb_write_data: got %h expected deadabef", wd); end
      n_checks++; if (wa !== 32'h12C) begin n_fail++; $display("FAIL sb_write_addr: got %h expected 12c", wa); end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d expected 3", lat); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sb_rdata: got %h expected 0", rd); end
      n_checks++; if (mem[75] !== 32'hDEAD_ABEF) begin n_fail++; $display("FAIL sb_memory: got %h expected deadabef", mem[75]); end
      model_req(1'b1, 3'b010, 32'h130, 32'h1234_5678, e_rd, e_ms, e_wr, e_lat, e_wa);
      do_req(1'b1, 3'b010, 32'h130, 32'h1234_5678, rd, ms, lat, nwr, wk, wd, wa);
      n_checks++; if (nwr !== 1) begin n_fail++; $display("FAIL sw_writes: got %0d expected 1", nwr); end
      n_checks++; if (wk !== 1) begin n_fail++; $display("FAIL sw_write_cycle: got %0d expected 1", wk); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
      n_checks++; if (mem[76] !== 32'h1234_5678) begin n_fail++; $display("FAIL sw_memory: got %h expected 12345678", mem[76]); end
   endtask

   task automatic test_reset_in_merge;
      int wait_n, saw;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12C; req_wdata = 32'h0000_5555;
      wait_n = 0;
      while (!req_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL merge_we_before_reset: got %b expected 1", mem_write_enable); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL merge_we_in_reset: got %b expected 0", mem_write_enable); end
      saw = 0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) saw++;
      end
      rst_n = 1'b1;
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL merge_ready_after_reset: got %b expected 1", req_ready); end
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) saw++;
      end
      n_checks++; if (saw !== 0) begin n_fail++; $display("FAIL merge_no_response: got %0d expected 0", saw); end
      n_checks++; if (mem[75] !== ref_mem[75]) begin n_fail++; $display("FAIL merge_memory_unchanged: got %h expected %h", mem[75], ref_mem[75]); end
   endtask

   task automatic test_random;
      logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [31:0] rd, wa, wd, e_rd, e_wa, addr, wdata;
      logic ms, e_ms, e_wr, we;
      logic [2:0] f3;
      int lat, nwr, wk, e_lat, pick;
      for (int i = 0; i < 60; i++) begin
         we    = 1'($urandom_range(0, 1));
         pick  = $urandom_range(0, 7);
         f3    = (pick < 5) ? legal[pick] : 3'($urandom_range(0, 7));
         addr  = 32'h100 + 32'($urandom_range(0, 63));
         wdata = $urandom;
         model_req(we, f3, addr, wdata, e_rd, e_ms, e_wr, e_lat, e_wa);
         do_req(we, f3, addr, wdata, rd, ms, lat, nwr, wk, wd, wa);
         n_checks++; if (rd !== e_rd) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h (we=%b f3=%b a=%h)", i, rd, e_rd, we, f3, addr); end
         n_checks++; if (ms !== e_ms) begin n_fail++; $display("FAIL rand_mis[%0d]: got %b expected %b", i, ms, e_ms); end
         n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, e_lat); end
         n_checks++; if (nwr !== int'(e_wr)) begin n_fail++; $display("FAIL rand_writes[%0d]: got %0d expected %0d", i, nwr, e_wr); end
         if (e_wr) begin
            n_checks++; if (wa !== e_wa) begin n_fail++; $display("FAIL rand_waddr[%0d]: got %h expected %h", i, wa, e_wa); end
         end
      end
   endtask

   task automatic test_back_to_back;
      localparam int NB = 16;
      int sent, got, exp_writes, writes, guard, tmo, e_lat;
      logic [31:0] e_rd, e_wa, a;
      logic e_ms, e_wr;
      logic [32:0] exp_v;
      sent = 0; got = 0; exp_writes = 0; writes = 0;
      exp_q.delete();
      fork
         begin
            guard = 0;
            req_valid = 1'b1;
            while (sent < NB && guard < 400) begin
               @(negedge clk);
               guard++;
               if (req_ready) begin
                  req_we     = sent[0];
                  req_funct3 = sent[0] ? 3'b000 : 3'b010;
                  a          = 32'h100 + 32'($urandom_range(0, 63));
                  req_addr   = sent[0] ? a : {a[31:2], 2'b00};
                  req_wdata  = $urandom;
                  model_req(req_we, req_funct3, req_addr, req_wdata, e_rd, e_ms, e_wr, e_lat, e_wa);
                  exp_q.push_back({e_ms, e_rd});
                  if (e_wr) exp_writes++;
                  sent++;
               end else begin
                  req_we = 1'($urandom); req_funct3 = 3'($urandom_range(0, 7));
                  req_addr = $urandom; req_wdata = $urandom;
               end
            end
            @(negedge clk);
            req_valid = 1'b0;
         end
         begin
            tmo = 0;
            while (got < NB && tmo < 600) begin
               @(negedge clk);
               tmo++;
               if (mem_write_enable) writes++;
               if (resp_valid) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_fail++; $display("FAIL b2b_unexpected_resp: got %b/%h expected none", resp_misaligned, resp_rdata);
                  end else begin
                     exp_v = exp_q.pop_front();
                     if ({resp_misaligned, resp_rdata} !== exp_v) begin
                        n_fail++; $display("FAIL b2b_resp[%0d]: got %b/%h expected %b/%h", got, resp_misaligned, resp_rdata, exp_v[32], exp_v[31:0]);
                     end
                  end
                  got++;
               end
            end
         end
      join
      repeat (4) @(negedge clk);
      n_checks++; if (got !== NB) begin n_fail++; $display("FAIL b2b_resp_count: got %0d expected %0d", got, NB); end
      n_checks++; if (writes !== exp_writes) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected %0d", writes, exp_writes); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra_resp: got %b expected 0", resp_valid); end
   endtask

   task automatic test_final_memory;
      int bad, first;
      bad = 0; first = -1;
      for (int i = 0; i < MEM_WORDS; i++) begin
         if (mem[i] !== ref_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL final_memory: got %0d differing words (first %0d) expected 0", bad, first); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      logic [31:0] v;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      rst_n = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         v = (i == 75) ? 32'hDEAD_BEEF : $urandom;
         mem[i]     <= v;
         ref_mem[i]  = v;
      end
      test_reset();
      test_loads();
      test_misaligned();
      test_stores();
      test_reset_in_merge();
      test_random();
      test_back_to_back();
      test_final_memory();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, the word depth of the attached data memory (informational; no range check).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit, pipeline presents a memory request.
REQ-005 SHALL have port req_ready, output, 1 bit, unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits, RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
REQ-008 SHALL have port req_addr, input, 32 bits, byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits, store data (low bits used for B/H).
REQ-010 SHALL have port resp_valid, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32 bits, extended load result (0 for stores).
REQ-012 SHALL have port resp_misaligned, output, 1 bit, request was rejected; valid with resp_valid.
REQ-013 SHALL have port mem_address, output, 32 bits, word-aligned address to data memory.
REQ-014 SHALL have ports mem_write_data (output, 32 bits) and mem_write_enable (output, 1 bit) driving the memory write port.
REQ-015 SHALL have port mem_read_data, input, 32 bits, combinational read data for mem_address.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, MERGE, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL, in IDLE on req_valid&req_ready, register we/funct3/addr/wdata and enter ACCESS.
REQ-018 SHALL drive mem_address = {addr_q[31:2],2'b00} in ACCESS and MERGE, and 0 otherwise.
REQ-019 SHALL, for loads in ACCESS, extract byte addr_q[1:0] or halfword addr_q[1], sign-extend (B/H) or zero-extend (BU/HU), register it into resp_rdata and enter RESP.
REQ-020 SHALL, for SW in ACCESS, assert mem_write_enable with mem_write_data = wdata_q for exactly that cycle, then enter RESP.
REQ-021 SHALL, for SB/SH in ACCESS, capture mem_read_data into a merge register and enter MERGE.
REQ-022 SHALL, in MERGE, write the captured word with only the addressed byte/halfword replaced by wdata_q[7:0]/[15:0] (one write cycle), then enter RESP.
REQ-023 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; resp_rdata holds until the next completion.
REQ-024 SHALL give latency from accept edge N: load and SW resp_valid in cycle N+2; SB/SH in N+3; throughput is one request per 3 (or 4) cycles.
REQ-025 SHALL treat funct3 100/101 with req_we=1 and funct3 011/110/111 as misaligned (illegal).
REQ-026 SHALL assert mem_write_enable only in ACCESS (SW) or MERGE (SB/SH), never in IDLE or RESP.
REQ-027 SHALL ignore req_valid while req_ready is 0; request inputs may change freely then.

Reset
REQ-028 SHALL, while rst_n = 0, force state IDLE, resp_valid 0, resp_rdata 0, resp_misaligned 0, mem_write_enable 0, mem_address 0.
REQ-029 SHALL, on reset during ACCESS or MERGE, deassert mem_write_enable immediately and discard the request with no response.
REQ-030 SHALL present req_ready = 1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat H at addr[0]=1, W at addr[1:0]!=0, and REQ-025 codes as misaligned: no memory write, RESP entered from ACCESS with resp_misaligned = 1, resp_rdata = 0.
REQ-032 SHALL, without LSU_MISALIGN_TRAP_EN, tie resp_misaligned to 0, force offending address bits to natural alignment (H: addr[0]=0; W: addr[1:0]=0), and treat illegal codes as W.

Verification
REQ-033 SHALL cover: word 75 = 0xDEADBEEF, LB addr 0x12F -> resp_rdata 0xFFFFFFDE at N+2; LBU 0x12C -> 0x000000EF.
REQ-034 SHALL cover: LH 0x12E -> 0xFFFFDEAD; LHU 0x12C -> 0x0000BEEF; LW 0x12C -> 0xDEADBEEF.
REQ-035 SHALL cover: SB wdata 0x000000AB addr 0x12D -> one write in N+2 of 0xDEADABEF, resp_valid N+3; SW 0x12345678 at 0x130 -> single write, resp_valid N+2.
REQ-036 SHALL cover (macro defined): LW 0x12E -> resp_misaligned 1, resp_rdata 0, mem_write_enable never asserted; macro undefined -> reads 0xDEADBEEF.
REQ-037 SHALL cover: rst_n low during MERGE of SH -> mem_write_enable drops that cycle, memory unchanged, no resp_valid, req_ready 1 after release.
REQ-038 SHALL cover: req_valid held high continuously with back-to-back LW/SB -> each accepted only in IDLE, responses in order, no dropped or duplicated request.
